mem_stage: RTL
==============

Name: mem_stage

Overview:
- LEGv8 pipelined CPU memory-access stage, between the EX/MEM register and the MEM/WB register.
- Drives the data-memory request/acknowledge handshake for LDUR/STUR-family ops and size-extracts load data into the MEM/WB read-memory input.
- Stalls the front of the pipe while a transfer is outstanding and inserts bubbles into MEM/WB.
- Aborts transfers that time out or are misaligned.

Parameters:
- WORDSIZE, 64, datapath/address width.
- TIMEOUT, 16, max cycles in WAIT before abort (>=2).
- CNTW, 5, counter width; must satisfy 2^CNTW > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- nopin  in  1  EX/MEM slot is a bubble.
- memread  in  1  load op.
- memwrite  in  1  store op.
- size  in  2  00 byte, 01 half, 10 word, 11 doubleword.
- signext  in  1  sign-extend load (LDURSW); else zero-extend.
- addr  in  WORDSIZE  effective address (ALU result).
- wdata  in  WORDSIZE  store data, right-aligned.
- dmem_req  out  1  request valid.
- dmem_we  out  1  write enable.
- dmem_addr  out  WORDSIZE  {addr[WORDSIZE-1:3],3'b000}.
- dmem_wdata  out  WORDSIZE  wdata shifted left by addr[2:0]*8.
- dmem_wstrb  out  8  byte-lane enables.
- dmem_rdata  in  WORDSIZE  aligned doubleword, valid with ack.
- dmem_ack  in  1  transfer complete.
- readmem  out  WORDSIZE  extracted/extended load data, to MEM/WB.
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
- nopout  out  1  drive MEM/WB nop.
- align_fault  out  1  one-cycle pulse: misaligned op dropped.
- bus_fault  out  1  one-cycle pulse: timeout abort.

Behaviour:
- State: IDLE, WAIT; wait counter cnt (CNTW bits). Reset: IDLE, cnt=0.
- Outputs are combinational from state, inputs and cnt. While rst is high: dmem_req=0, stall=0, nopout=1, faults=0, readmem=0.
- op = (memread|memwrite) & !nopin. Both memread and memwrite set is treated as a store.
- Misaligned: addr not a multiple of 2^size. Checked in IDLE only.
  - Result: align_fault=1, dmem_req=0, stall=0, nopout=1, remain IDLE.
- Lanes, little-endian, lane = addr[2:0]. wstrb = (2^(2^size))-1 shifted left by lane.
  - dmem_we = memwrite. dmem_wstrb is also driven on reads.
- IDLE:
  - No op: stall=0, nopout=nopin, readmem=0, dmem_req=0.
  - Aligned op: dmem_req=1. ack same cycle → complete (zero-wait), stay IDLE. No ack → stall=1, nopout=1, go WAIT, cnt<=1.
- WAIT:
  - dmem_req=1; addr, we, wdata and wstrb stable, guaranteed by the frozen EX/MEM.
  - ack → complete, go IDLE, cnt<=0.
  - No ack and cnt==TIMEOUT → abort: dmem_req=0, bus_fault=1, stall=0, nopout=1, go IDLE, cnt<=0.
  - Otherwise stall=1, nopout=1, cnt<=cnt+1.
- Complete cycle:
  - stall=0, nopout=0.
  - Load: readmem = (dmem_rdata >> lane*8) truncated to 8/16/32/64 bits, sign-extended if signext, else zero-extended. Store: readmem=0.
  - EX/MEM advances at this edge, so the op is never re-issued.
- ack in WAIT at cnt==TIMEOUT counts as completion; ack wins over timeout.
- ack while dmem_req=0 is ignored.
- Reset mid-WAIT: immediately IDLE, dmem_req drops asynchronously. The memory shares rst, so no late ack is tracked.

Test Plan:
- Zero-wait LDUR: size=11, addr=0x1000, ack same cycle, rdata=0x1122334455667788 → stall=0, nopout=0, readmem=0x1122334455667788, state IDLE.
- LDURSW, 3-cycle latency: addr=0x2004, size=10, signext=1, ack on 3rd req cycle, rdata=0x80000001_00000000 → stall high for 2 cycles, nopout=1 each, then readmem=0xFFFFFFFF80000001.
- STURB: addr=0x3003, wdata=0xAB, ack same cycle → dmem_we=1, wstrb=0x08, dmem_wdata[31:24]=0xAB, dmem_addr=0x3000.
- Misaligned LDUR at addr=0x1004, size=11 → align_fault=1, dmem_req=0, stall=0, nopout=1.
- Timeout, TIMEOUT=16, no ack → stall high 16 cycles, then bus_fault pulse, dmem_req=0, IDLE. Repeat with ack at cnt==16 → completes, no fault.
- Reset asserted in WAIT (cnt=5) → dmem_req=0 and stall=0 immediately. After release, state IDLE, cnt=0, non-mem op passes with nopout=nopin.

Source files
------------

// File: rtl/mem_stage.sv
// LEGv8 memory-access stage: drives the data-memory req/ack handshake, extracts
// load data for MEM/WB, and stalls the front of the pipe while a transfer is open.
module mem_stage #(
    parameter int WORDSIZE = 64,
    parameter int TIMEOUT  = 16,
    parameter int CNTW     = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                nopin,
    input  logic                memread,
    input  logic                memwrite,
    input  logic [1:0]          size,
    input  logic                signext,
    input  logic [WORDSIZE-1:0] addr,
    input  logic [WORDSIZE-1:0] wdata,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [WORDSIZE-1:0] dmem_addr,
    output logic [WORDSIZE-1:0] dmem_wdata,
    output logic [7:0]          dmem_wstrb,
    input  logic [WORDSIZE-1:0] dmem_rdata,
    input  logic                dmem_ack,
    output logic [WORDSIZE-1:0] readmem,
    output logic                stall,
    output logic                nopout,
    output logic                align_fault,
    output logic                bus_fault,
    output logic                dbg_state_o,
    output logic [CNTW-1:0]     dbg_cnt_o
);

    // Handshake: dmem_req is held high from the first request cycle until the
    // cycle dmem_ack is seen (transfer completes) or the wait budget runs out;
    // dmem_ack while dmem_req is low carries no meaning.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;

    logic              op;
    logic              misaligned;
    logic              complete;
    logic [2:0]        lane;
    logic [7:0]        strb_base;
    logic [WORDSIZE-1:0] rshift;
    logic [WORDSIZE-1:0] load_val;

    assign op   = (memread | memwrite) & ~nopin;
    assign lane = addr[2:0];

    always_comb begin
        misaligned = 1'b0;
        strb_base  = 8'h01;
        case (size)
            2'b00: begin misaligned = 1'b0;        strb_base = 8'h01; end
            2'b01: begin misaligned = addr[0];     strb_base = 8'h03; end
            2'b10: begin misaligned = |addr[1:0];  strb_base = 8'h0F; end
            default: begin misaligned = |addr[2:0]; strb_base = 8'hFF; end
        endcase
    end

    assign dmem_we    = memwrite;
    assign dmem_addr  = {addr[WORDSIZE-1:3], 3'b000};
    assign dmem_wdata = wdata << {lane, 3'b000};
    assign dmem_wstrb = strb_base << lane;

    assign rshift = dmem_rdata >> {lane, 3'b000};

    always_comb begin
        load_val = rshift;
        case (size)
            2'b00: load_val = {{(WORDSIZE-8){signext & rshift[7]}}, rshift[7:0]};
            2'b01: load_val = {{(WORDSIZE-16){signext & rshift[15]}}, rshift[15:0]};
            2'b10: load_val = {{(WORDSIZE-32){signext & rshift[31]}}, rshift[31:0]};
            default: load_val = rshift;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dmem_req    = 1'b0;
        stall       = 1'b0;
        nopout      = 1'b1;
        align_fault = 1'b0;
        bus_fault   = 1'b0;
        complete    = 1'b0;
        readmem     = '0;
        case (state_q)
            IDLE: begin
                if (!op) begin
                    nopout = nopin;
                end else if (misaligned) begin
                    align_fault = 1'b1;
                end else begin
                    dmem_req = 1'b1;
                    if (dmem_ack) begin
                        complete = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = WAIT;
                        cnt_d   = CNTW'(1);
                    end
                end
            end
            WAIT: begin
                dmem_req = 1'b1;
                // Ack is tested before the budget so a last-cycle ack still completes.
                if (dmem_ack) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end else if (cnt_q == CNTW'(TIMEOUT)) begin
                    dmem_req  = 1'b0;
                    bus_fault = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (complete) begin
            nopout  = 1'b0;
            readmem = (memread & ~memwrite) ? load_val : '0;
        end
        // Reset gates the outputs combinationally so dmem_req drops at once.
        if (rst) begin
            dmem_req    = 1'b0;
            stall       = 1'b0;
            nopout      = 1'b1;
            align_fault = 1'b0;
            bus_fault   = 1'b0;
            readmem     = '0;
        end
    end

    assign dbg_state_o = state_q;
    assign dbg_cnt_o   = cnt_q;

endmodule
